edge_pattern_gen: RTL and testbench

Edge-pattern transmitter: drives a single-bit line with rising and falling transitions on command, holding each level for a programmable minimum number of cycles. It is the stimulus/driver end of our edge-detection path: its output feeds an edge detector, and its own edge strobes match that detector's pos/neg outputs cycle-for-cycle in loopback. Commands arrive over a valid/ready handshake from a sequencer or testbench master.

---
 rtl/edge_pattern_gen.sv | 93 +++++++++
 tb/tb_edge_pattern_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/edge_pattern_gen.sv
// Edge-pattern transmitter: drives a_out to commanded levels and holds each for cmd_hold extra cycles.
// Latency: the accept edge updates a_out and the matching pos/neg strobe; the strobe lasts one cycle.
// Backpressure: cmd_ready is low for exactly cmd_hold cycles after each accept; valid/ready handshake.
module edge_pattern_gen #(
    parameter int   HOLD_W     = 8,
    parameter int   CNT_W      = 16,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_level,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic              a_out,
    output logic              pos_edge_tx,
    output logic              neg_edge_tx,
    output logic              busy,
    output logic [CNT_W-1:0]  edge_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
    logic               level_nxt;
    logic               pos_nxt, neg_nxt;
    logic [CNT_W-1:0]   count_nxt;
    logic               accept;

    assign cmd_ready = (state == IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid & cmd_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            a_out       <= IDLE_LEVEL;
            pos_edge_tx <= 1'b0;
            neg_edge_tx <= 1'b0;
            edge_count  <= '0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            a_out       <= level_nxt;
            pos_edge_tx <= pos_nxt;
            neg_edge_tx <= neg_nxt;
            edge_count  <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        level_nxt = a_out;
        pos_nxt   = 1'b0;
        neg_nxt   = 1'b0;
        count_nxt = edge_count;
        case (state)
            IDLE: begin
                if (accept) begin
                    level_nxt = cmd_level;
                    hold_nxt  = cmd_hold;
                    // A same-level command is a pure delay: no strobe, no count.
                    if (cmd_level != a_out) begin
                        pos_nxt   = cmd_level;
                        neg_nxt   = ~cmd_level;
                        count_nxt = edge_count + CNT_W'(1);
                    end
                    if (cmd_hold != '0) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                hold_nxt = hold_cnt - HOLD_W'(1);
                // <= 1 also recovers if hold_cnt were ever zero here.
                if (hold_cnt <= HOLD_W'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                hold_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_edge_pattern_gen.sv
// Scoreboard bench for edge_pattern_gen: randomized commands, reference expectations queued
// at issue time, a negedge monitor comparing outputs plus a loopback edge detector.
module tb_edge_pattern_gen;

    localparam int   HOLD_W = 8;
    localparam int   CNT_W  = 4;
    localparam logic IDLE_L = 1'b0;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_level;
    logic [HOLD_W-1:0] cmd_hold;
    logic              a_out;
    logic              pos_edge_tx;
    logic              neg_edge_tx;
    logic              busy;
    logic [CNT_W-1:0]  edge_count;

    edge_pattern_gen #(
        .HOLD_W    (HOLD_W),
        .CNT_W     (CNT_W),
        .IDLE_LEVEL(IDLE_L)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_level  (cmd_level),
        .cmd_hold   (cmd_hold),
        .a_out      (a_out),
        .pos_edge_tx(pos_edge_tx),
        .neg_edge_tx(neg_edge_tx),
        .busy       (busy),
        .edge_count (edge_count)
    );

    always #5 clk = ~clk;

    // Receiving-end edge detector for the loopback comparison.
    logic a_prev;
    logic det_pos, det_neg;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) a_prev <= IDLE_L;
        else          a_prev <= a_out;
    end
    assign det_pos = a_out & ~a_prev;
    assign det_neg = ~a_out & a_prev;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned      edge_n;
        logic             level;
        logic             pos;
        logic             neg;
        logic [CNT_W-1:0] count;
    } exp_t;

    exp_t             q[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    logic             lvl_m    = IDLE_L;
    logic [CNT_W-1:0] count_m  = '0;
    int unsigned      free_edge = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at cycle %0d", name, act, req, cyc);
    endtask

    // Monitor: outputs are examined on the falling edge, away from the active edge.
    initial begin : monitor
        logic             acc_prev;
        logic             mon_level;
        logic [CNT_W-1:0] mon_count;
        exp_t             e;
        acc_prev  = 1'b0;
        mon_level = IDLE_L;
        mon_count = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_a_out", a_out, IDLE_L);
                chk("rst_strobes", {pos_edge_tx, neg_edge_tx}, 0);
                chk("rst_ready", cmd_ready, 1);
                chk("rst_busy", busy, 0);
                chk("rst_count", edge_count, 0);
                acc_prev  = 1'b0;
                mon_level = IDLE_L;
                mon_count = '0;
            end else begin
                if (acc_prev) begin
                    if (q.size() == 0) begin
                        chk("unexpected_accept", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("accept_edge", cyc, e.edge_n);
                        chk("acc_a_out", a_out, e.level);
                        chk("acc_pos", pos_edge_tx, e.pos);
                        chk("acc_neg", neg_edge_tx, e.neg);
                        chk("acc_count", edge_count, e.count);
                        mon_level = e.level;
                        mon_count = e.count;
                    end
                end else begin
                    chk("hold_a_out", a_out, mon_level);
                    chk("idle_strobes", {pos_edge_tx, neg_edge_tx}, 0);
                    chk("idle_count", edge_count, mon_count);
                end
                chk("ready", cmd_ready, (cyc + 1 >= free_edge) ? 1 : 0);
                chk("busy", busy, !cmd_ready);
                chk("loop_pos", det_pos, pos_edge_tx);
                chk("loop_neg", det_neg, neg_edge_tx);
                acc_prev = cmd_valid && cmd_ready;
            end
        end
    end

    // Issue one command at posedge+2; returns at posedge+2 of its accept edge.
    task automatic send(input logic lvl, input int hold);
        exp_t        e;
        int          t;
        int unsigned k;
        logic        chg;
        k        = cyc;
        e.edge_n = (k + 1 > free_edge) ? k + 1 : free_edge;
        chg      = (lvl != lvl_m);
        if (chg) count_m = count_m + 1'b1;
        e.level  = lvl;
        e.pos    = chg && lvl;
        e.neg    = chg && !lvl;
        e.count  = count_m;
        lvl_m    = lvl;
        q.push_back(e);
        cmd_valid = 1'b1;
        cmd_level = lvl;
        cmd_hold  = HOLD_W'(hold);
        t = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            t++;
            if (t > 300) break;
        end
        if (t > 300) begin
            chk("accept_timeout", 0, 1);
            void'(q.pop_back());
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #2;
            free_edge = cyc + hold + 1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin : stimulus
        logic [CNT_W-1:0] base;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_level = 1'b0;
        cmd_hold  = '0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        idle(5);

        // Rise with hold 3; the follow-up must wait until edge N+4.
        send(1'b1, 3);
        send(1'b0, 0);

        // Back-to-back toggling with zero hold.
        base = edge_count;
        send(1'b1, 0);
        send(1'b0, 0);
        send(1'b1, 0);
        send(1'b0, 0);
        idle(1);
        chk("toggle_delta", edge_count - base, 4);

        // Same-level command acts as a pure delay.
        send(1'b1, 0);
        base = edge_count;
        send(1'b1, 2);
        send(1'b0, 0);
        idle(1);
        chk("same_level_delta", edge_count - base, 1);

        // Randomized traffic with idle gaps.
        for (int i = 0; i < 40; i++) begin
            send(1'($urandom_range(1, 0)), int'($urandom_range(5, 0)));
            idle(int'($urandom_range(2, 0)));
        end
        idle(8);

        // Reset mid-hold, asserted away from the clock edge.
        send(1'b1, 200);
        repeat (100) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_a_out", a_out, IDLE_L);
        chk("async_ready", cmd_ready, 1);
        chk("async_count", edge_count, 0);
        q.delete();
        lvl_m     = IDLE_L;
        count_m   = '0;
        free_edge = 0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        idle(3);

        // 17 alternating commands wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            send(1'((i + 1) % 2), int'($urandom_range(2, 0)));
        end
        idle(4);
        chk("wrap_count", edge_count, 1);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
